prog_delay_ctrl: RTL and testbench
==================================

// Module: prog_delay_ctrl
// PURPOSE
//  Programmable-depth delay controller for the 25-bit signed sample path. Replaces fixed
//  per-stage delay chains: delays a valid-qualified stream by cfg_delay samples (1..MAX_DELAY)
//  using a circular buffer. It sequences fill/run phases and zero-primes the output exactly
//  as a reset register chain would.
// PARAMETERS
//  DATA_W     25   sample width, two's complement
//  MAX_DELAY  16   largest delay in samples; also buffer depth (any value >= 2)
//  CNT_W      $clog2(MAX_DELAY+1)  derived localparam: width of delay/fill counters
// PORTS
//  clk        in   1        rising-edge clock, single clock domain
//  reset      in   1        asynchronous, active-low reset
//  cfg_delay  in   CNT_W    requested delay in samples; sampled only when cfg_load=1
//  cfg_load   in   1        one-cycle strobe: latch cfg_delay, restart fill
//  in_valid   in   1        data_in holds a sample this cycle
//  data_in    in   DATA_W   signed input sample
//  out_valid  out  1        data_out holds a sample this cycle
//  data_out   out  DATA_W   signed delayed sample
//  busy       out  1        1 while in FILL (output still zero-primed)
//  cfg_err    out  1        one-cycle pulse: last cfg_delay out of range and clamped
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, delay reg=MAX_DELAY, wr_ptr=0, fill_cnt=0, out_valid=0,
//    data_out=0, busy=0, cfg_err=0. Buffer contents need no reset (never read before written).
//  - FSM: IDLE -(first in_valid or cfg_load)-> FILL -(fill_cnt reaches delay)-> RUN;
//    cfg_load in any state -> FILL with fill_cnt=0. IDLE->FILL on in_valid counts that sample.
//  - Per accepted sample (in_valid=1): write data_in at wr_ptr; wr_ptr wraps MAX_DELAY-1 -> 0.
//  - Latency: out_valid = in_valid delayed exactly 1 cycle; one output per input, no stalls.
//  - data_out: 0 while fill_cnt < delay (FILL, busy=1); in RUN = sample written `delay`
//    accepted samples earlier: rd_addr = (wr_ptr - delay) mod MAX_DELAY.
//  - delay=MAX_DELAY: rd_addr == wr_ptr; buffer is read-before-write (old value returned).
//  - fill_cnt saturates at delay; FILL->RUN when the delay-th sample is accepted; sample
//    delay+1 is the first non-zero-primed output.
//  - cfg_delay=0 -> clamp to 1; cfg_delay>MAX_DELAY -> clamp to MAX_DELAY; either case
//    pulses cfg_err the cycle after cfg_load. In-range values: cfg_err stays 0.
//  - cfg_load with in_valid same cycle: new delay applies; that sample is fill sample #1;
//    its output (next cycle) is 0. Output of samples already in flight is not altered.
//  - in_valid=0 cycles: no pointer/count movement, out_valid=0, data_out holds last value.
//  - reset asserted mid-operation: immediate return to reset values; no partial output.
// CONFIGURATION
//  PDC_BYPASS_EN defined: adds input port `bypass` (1 bit). bypass=1 -> data_out = data_in
//   registered (1-cycle), out_valid as normal; buffer still written, FSM/fill_cnt still
//   advance, so deasserting bypass in RUN yields correctly delayed data immediately.
//  PDC_BYPASS_EN undefined: no bypass port; datapath always through the buffer.
// STRUCTURE
//  Shared package dsp_pkg: SAMPLE_W=25 constant, sample_t (signed [24:0]) typedef,
//   pdc_state_t enum {PDC_IDLE, PDC_FILL, PDC_RUN}.
//  One sub-module: pdc_ring_ram (MAX_DELAY x DATA_W, 1 write + 1 sync read port,
//   read-before-write on address collision, no reset on storage). FSM, pointers, clamp,
//   zero-priming mux live in prog_delay_ctrl.
// TESTING
//  1 reset, cfg_delay=6 load, in_valid every cycle, data_in=1,2,3.. -> outputs 0 x6, then
//    1,2,3..; out_valid 1 cycle after each in_valid; busy=1 for the 6 fill samples.
//  2 cfg_delay=16 (=MAX), data_in=-100..-85 then 7 -> first non-zero output -100 on the 17th
//    sample; wr_ptr wraps 15->0 with no glitch.
//  3 cfg_delay=0 -> cfg_err pulse, delay=1; cfg_delay=20 -> cfg_err, delay=16; cfg_delay=5 -> no err.
//  4 in_valid pattern 1,0,0,1,1,0,1 with cfg_delay=2, data 10,20,30,40 -> outputs 0,0,10,20
//    only on cycles after in_valid; data_out held during gaps.
//  5 in RUN with delay=4, cfg_load delay=2 alongside in_valid -> busy=1, next 2 outputs 0,
//    then delayed by 2; reset pulse mid-RUN -> all outputs 0, state IDLE next cycle.
//  6 PDC_BYPASS_EN: delay=3, bypass=1 for 5 samples -> data_out = data_in (1 cycle); drop
//    bypass -> next output = sample from 3 samples earlier, no zero-priming.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared sample-path types for the DSP delay blocks.
// Pure declarations: no logic, no latency, no flow control.
package dsp_pkg;

   localparam int SAMPLE_W = 25;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      PDC_IDLE,
      PDC_FILL,
      PDC_RUN
   } pdc_state_t;

endpackage

// File: rtl/pdc_ring_ram.sv
// Circular-buffer storage: 1 write + 1 registered read port, read-before-write on collision.
// Read latency 1 cycle; no backpressure, storage is not reset.
module pdc_ring_ram #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 25,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Non-blocking read and write on the same edge returns the old word on a collision.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/prog_delay_ctrl.sv
// Programmable 1..MAX_DELAY sample delay with zero-primed fill; 1-cycle valid latency, never stalls.
// Optional PDC_BYPASS_EN adds a `bypass` port that forwards data_in registered while the buffer keeps running.
module prog_delay_ctrl
   import dsp_pkg::*;
#(
   parameter  int DATA_W    = SAMPLE_W,
   parameter  int MAX_DELAY = 16,
   localparam int CNT_W     = $clog2(MAX_DELAY + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef PDC_BYPASS_EN
   input  logic                     bypass,
`endif
   input  logic [CNT_W-1:0]         cfg_delay,
   input  logic                     cfg_load,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     busy,
   output logic                     cfg_err
);

   localparam int               AW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
   localparam logic [CNT_W-1:0] MAX_D    = CNT_W'(MAX_DELAY);
   localparam logic [CNT_W:0]   MAX_P    = (CNT_W + 1)'(MAX_DELAY);
   localparam logic [AW-1:0]    LAST_PTR = AW'(MAX_DELAY - 1);

   pdc_state_t              state, state_n;
   logic [CNT_W-1:0]        delay_q, dly_eff, cnt_base, cnt_n, fill_cnt;
   logic [AW-1:0]           wr_ptr, rd_addr;
   logic [CNT_W:0]          rd_sum;
   logic                    fill_zero, zero_q;
   logic signed [DATA_W-1:0] ram_q;

   function automatic logic [CNT_W-1:0] clamp_dly(input logic [CNT_W-1:0] d);
      if (d == '0)        return CNT_W'(1);
      else if (d > MAX_D) return MAX_D;
      else                return d;
   endfunction

   // A load takes effect on the same cycle, so a sample arriving with it is fill sample #1.
   always_comb begin
      dly_eff   = cfg_load ? clamp_dly(cfg_delay) : delay_q;
      cnt_base  = cfg_load ? '0 : fill_cnt;
      fill_zero = (cnt_base < dly_eff);
      cnt_n     = (in_valid && fill_zero) ? cnt_base + CNT_W'(1) : cnt_base;
      rd_sum    = (CNT_W + 1)'(wr_ptr) + MAX_P - {1'b0, dly_eff};
      rd_addr   = (rd_sum >= MAX_P) ? AW'(rd_sum - MAX_P) : AW'(rd_sum);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= PDC_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (cfg_load || in_valid || state != PDC_IDLE)
         state_n = (cnt_n == dly_eff) ? PDC_RUN : PDC_FILL;
   end

   always_comb begin
      busy = (state == PDC_FILL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         delay_q   <= MAX_D;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         zero_q    <= 1'b1;
         cfg_err   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         cfg_err   <= cfg_load && (cfg_delay == '0 || cfg_delay > MAX_D);
         fill_cnt  <= cnt_n;
         if (cfg_load) delay_q <= dly_eff;
         if (in_valid) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
            zero_q <= fill_zero;
         end
      end
   end

   pdc_ring_ram #(
      .DEPTH (MAX_DELAY),
      .WIDTH (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (in_valid),
      .waddr (wr_ptr),
      .wdata (data_in),
      .re    (in_valid),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

`ifdef PDC_BYPASS_EN
   logic                     byp_q;
   logic signed [DATA_W-1:0] din_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byp_q <= 1'b0;
         din_q <= '0;
      end else if (in_valid) begin
         byp_q <= bypass;
         din_q <= data_in;
      end
   end

   assign data_out = byp_q ? din_q : (zero_q ? '0 : ram_q);
`else
   assign data_out = zero_q ? '0 : ram_q;
`endif

endmodule

// File: tb/tb_prog_delay_ctrl.sv
// Bench for prog_delay_ctrl: directed scenarios plus randomized traffic against a history-based model.
module tb_prog_delay_ctrl;
   import dsp_pkg::*;

   localparam int MAXD = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] cfg_delay = '0;
   logic       cfg_load = 1'b0;
   logic       in_valid = 1'b0;
   sample_t    data_in = '0;
   logic       bypass = 1'b0;
   logic       out_valid, busy, cfg_err;
   sample_t    data_out;

   prog_delay_ctrl dut (
      .clk       (clk),
      .reset     (reset),
`ifdef PDC_BYPASS_EN
      .bypass    (bypass),
`endif
      .cfg_delay (cfg_delay),
      .cfg_load  (cfg_load),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_valid (out_valid),
      .data_out  (data_out),
      .busy      (busy),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   // Model: full history of accepted samples; the first D samples after a fill start read as zero.
   int      m_delay;
   bit      m_started;
   int      m_fcount;
   sample_t hist[$];
   bit      ov_e, busy_e, err_e;
   sample_t dout_e;
   int      vec = 0;
   int      miss = 0;

   function automatic int clamp_m(input int d);
      if (d < 1) return 1;
      if (d > MAXD) return MAXD;
      return d;
   endfunction

   task automatic model_reset();
      m_delay   = MAXD;
      m_started = 0;
      m_fcount  = 0;
      hist.delete();
      ov_e = 0; busy_e = 0; err_e = 0; dout_e = '0;
   endtask

   task automatic step(input bit ld, input int dly, input bit v, input int d);
      cfg_load  = ld;
      cfg_delay = dly[4:0];
      in_valid  = v;
      data_in   = d[24:0];
      @(posedge clk);
      err_e = ld && (dly == 0 || dly > MAXD);
      if (ld) begin
         m_delay   = clamp_m(dly);
         m_fcount  = 0;
         m_started = 1;
      end
      ov_e = v;
      if (v) begin
         m_started = 1;
         hist.push_back(data_in);
         if (bypass)                  dout_e = data_in;
         else if (m_fcount < m_delay) dout_e = '0;
         else                         dout_e = hist[hist.size() - 1 - m_delay];
         m_fcount++;
      end
      busy_e = m_started && (m_fcount < m_delay);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      reset = 1'b0;
      #12;
      vec++;
      if ({out_valid, busy, cfg_err} !== 3'b000 || data_out !== '0) begin
         miss++;
         $display("FAIL reset_hold ov/busy/err=%b%b%b dout=%0d, expected 000 dout=0", out_valid, busy, cfg_err, data_out);
      end
      @(negedge clk) reset = 1'b1;
      step(0, 0, 0, 0);
      vec++;
      if ({out_valid, busy, cfg_err} !== 3'b000 || data_out !== '0) begin
         miss++;
         $display("FAIL reset_idle ov/busy/err=%b%b%b dout=%0d, expected 000 dout=0", out_valid, busy, cfg_err, data_out);
      end
   endtask

   task automatic test_fill_run();
      step(1, 6, 0, 0);
      vec++;
      if ({out_valid, busy, cfg_err} !== 3'b010) begin
         miss++;
         $display("FAIL fill_load ov/busy/err=%b%b%b, expected 010", out_valid, busy, cfg_err);
      end
      for (int i = 1; i <= 20; i++) begin
         step(0, 0, 1, i);
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL fill_run s=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
      end
   endtask

   task automatic test_max_delay();
      step(1, 16, 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1, (i < 16) ? -100 + i : ((i == 16) ? 7 : int'($urandom)));
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL max_delay s=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i + 1, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
         if (i == 16) begin
            vec++;
            if (data_out !== -25'sd100) begin
               miss++;
               $display("FAIL max_first_out got %0d, expected -100", data_out);
            end
         end
      end
   endtask

   task automatic test_clamp();
      int dl[3] = '{0, 20, 5};
      bit el[3] = '{1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         step(1, dl[k], 0, 0);
         vec++;
         if (cfg_err !== el[k]) begin
            miss++;
            $display("FAIL clamp_err cfg=%0d got %b, expected %b", dl[k], cfg_err, el[k]);
         end
         step(0, 0, 0, 0);
         vec++;
         if (cfg_err !== 1'b0) begin
            miss++;
            $display("FAIL clamp_pulse cfg=%0d err still %b, expected 0", dl[k], cfg_err);
         end
         for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, int'($urandom));
            vec++;
            if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
               miss++;
               $display("FAIL clamp_stream cfg=%0d s=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                        dl[k], i + 1, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
            end
         end
      end
   endtask

   task automatic test_gaps();
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int dv[4] = '{10, 20, 30, 40};
      int n = 0;
      step(1, 2, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(0, 0, pat[i], pat[i] ? dv[n] : 99);
         if (pat[i]) n++;
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL gaps c=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
      end
   endtask

   task automatic test_reload_reset();
      step(1, 4, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 10) step(1, 2, 1, int'($urandom));
         else         step(0, 0, 1, int'($urandom));
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL reload s=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i + 1, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
      end
      #2 reset = 1'b0;
      #1;
      vec++;
      if ({out_valid, busy, cfg_err} !== 3'b000 || data_out !== '0) begin
         miss++;
         $display("FAIL mid_reset ov/busy/err=%b%b%b dout=%0d, expected 000 dout=0", out_valid, busy, cfg_err, data_out);
      end
      model_reset();
      in_valid = 1'b0;
      cfg_load = 1'b0;
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 22; i++) begin
         step(0, 0, (i != 0), int'($urandom));
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL post_reset c=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 24) == 0), int'($urandom_range(0, 20)),
              ($urandom_range(0, 3) != 0), int'($urandom));
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL random c=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
      end
   endtask

`ifdef PDC_BYPASS_EN
   task automatic test_bypass();
      step(1, 3, 0, 0);
      for (int i = 0; i < 10; i++) begin
         bypass = (i < 5);
         step(0, 0, 1, 1000 + i);
         vec++;
         if ({out_valid, busy, cfg_err} !== {ov_e, busy_e, err_e} || data_out !== dout_e) begin
            miss++;
            $display("FAIL bypass s=%0d ov/busy/err=%b%b%b dout=%0d, expected %b%b%b dout=%0d",
                     i + 1, out_valid, busy, cfg_err, data_out, ov_e, busy_e, err_e, dout_e);
         end
      end
      bypass = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_fill_run();
      test_max_delay();
      test_clamp();
      test_gaps();
      test_reload_reset();
`ifdef PDC_BYPASS_EN
      test_bypass();
`endif
      test_random();
      step(0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
